if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_pkg.sv | 36 +++
 rtl/if_stage_if_id_reg.sv | 41 ++++
 rtl/if_stage.sv | 86 ++++++++
 tb/tb_if_stage.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared CPU constants: special instruction words, fetch states, opcodes
package if_stage_pkg;

  localparam logic [31:0] HALT_INST = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_INST  = 32'h0000_0000;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  // Control applied to the IF/ID pipeline register each cycle
  typedef enum logic [1:0] {
    IFID_LOAD  = 2'd0,
    IFID_HOLD  = 2'd1,
    IFID_FLUSH = 2'd2
  } ifid_op_t;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_IMM    = 7'b0010011,
    OP_AUIPC  = 7'b0010111,
    OP_STORE  = 7'b0100011,
    OP_REG    = 7'b0110011,
    OP_LUI    = 7'b0110111,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111,
    OP_SYSTEM = 7'b1110011
  } opcode_t;

  function automatic logic is_halt(input logic [31:0] word);
    return word == HALT_INST;
  endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// rtl/if_stage_if_id_reg.sv - IF/ID pipeline register with load, hold and flush
module if_id_reg
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  ifid_op_t    op,
  input  logic [31:0] inst_in,
  input  logic [31:0] pc_in,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        valid
);

  always_ff @(posedge clk) begin
    if (rst) begin
      inst  <= NOP_INST;
      pc    <= 32'h0;
      valid <= 1'b0;
    end else begin
      unique case (op)
        IFID_LOAD: begin
          inst  <= inst_in;
          pc    <= pc_in;
          valid <= 1'b1;
        end
        IFID_FLUSH: begin
          inst  <= NOP_INST;
          pc    <= 32'h0;
          valid <= 1'b0;
        end
        default: begin
          inst  <= inst;
          pc    <= pc;
          valid <= valid;
        end
      endcase
    end
  end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC register, RUN/HALT FSM, IF/ID register
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_IF,
  output logic [31:0] inst_ID,
  output logic [31:0] pc_ID,
  output logic        valid_ID,
  output logic        halted
);

  logic [31:0]  pc;
  logic [31:0]  pc_seq;
  fetch_state_t state;
  ifid_op_t     ifid_op;

  assign imem_addr = pc;
  assign inst_IF   = imem_rdata;
  assign pc_seq    = pc + 32'(PC_STEP);

  // Priority: branch > stall > halt > sequential; reset is handled inside the register
  always_comb begin
    ifid_op = IFID_LOAD;
    if (branch_taken)       ifid_op = IFID_FLUSH;
    else if (stall)         ifid_op = IFID_HOLD;
    else if (state == HALT) ifid_op = IFID_FLUSH;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC;
      state  <= RUN;
      halted <= 1'b0;
    end else if (branch_taken) begin
      pc     <= branch_target;
      state  <= RUN;
      halted <= 1'b0;
    end else if (stall) begin
      pc     <= pc;
      state  <= state;
      halted <= halted;
    end else begin
      case (state)
        RUN: begin
          // The halt word itself still goes to IF/ID; PC freezes at its address
          if (is_halt(inst_IF)) begin
            pc     <= pc;
            state  <= HALT;
            halted <= 1'b1;
          end else begin
            pc     <= pc_seq;
            state  <= RUN;
            halted <= 1'b0;
          end
        end
        default: begin
          pc     <= pc;
          state  <= HALT;
          halted <= 1'b1;
        end
      endcase
    end
  end

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .op      (ifid_op),
    .inst_in (inst_IF),
    .pc_in   (pc_seq),
    .inst    (inst_ID),
    .pc      (pc_ID),
    .valid   (valid_ID)
  );

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] inst_IF;
  logic [31:0] inst_ID;
  logic [31:0] pc_ID;
  logic        valid_ID;
  logic        halted;

  logic [31:0] halt_addr = 32'h0000_0001;
  int vectors = 0;
  int miscompares = 0;

  logic [97:0] got, exp;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a == halt_addr) return 32'hFFFF_FFFF;
    return a ^ 32'h1300_0013;
  endfunction

  assign imem_rdata = rom(imem_addr);

  if_stage #(.RESET_PC(32'h0), .PC_STEP(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .inst_IF       (inst_IF),
    .inst_ID       (inst_ID),
    .pc_ID         (pc_ID),
    .valid_ID      (valid_ID),
    .halted        (halted)
  );

  task automatic step();
    @(posedge clk);
    #1;
    got = {imem_addr, inst_ID, pc_ID, valid_ID, halted};
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    exp = {32'h0, 32'h0, 32'h0, 1'b0, 1'b0};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL reset_state got=%h exp=%h", got, exp);
    end
    vectors++;
    if (inst_IF !== rom(32'h0)) begin
      miscompares++;
      $display("FAIL first_fetch inst_IF=%h exp=%h", inst_IF, rom(32'h0));
    end
  endtask

  task automatic test_free_run();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      step();
      exp = {32'(4 * i), rom(32'(4 * (i - 1))), 32'(4 * i), 1'b1, 1'b0};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL free_run_%0d got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    step();
    step();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      exp = {32'h8, rom(32'h4), 32'h8, 1'b1, 1'b0};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL stall_hold_%0d got=%h exp=%h", i, got, exp);
      end
    end
    stall = 1'b0;
    step();
    exp = {32'hC, rom(32'h8), 32'hC, 1'b1, 1'b0};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL stall_release got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_branch_over_stall();
    do_reset();
    for (int i = 0; i < 4; i++) step();
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h40;
    step();
    exp = {32'h40, 32'h0, 32'h0, 1'b0, 1'b0};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL branch_flush got=%h exp=%h", got, exp);
    end
    stall = 1'b0; branch_taken = 1'b0;
    step();
    exp = {32'h44, rom(32'h40), 32'h44, 1'b1, 1'b0};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL branch_resume got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_halt_stall_pending();
    halt_addr = 32'h20;
    do_reset();
    for (int i = 0; i < 8; i++) step();
    stall = 1'b1;
    step();
    step();
    exp = {32'h20, rom(32'h1C), 32'h20, 1'b1, 1'b0};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL halt_pending_stall got=%h exp=%h", got, exp);
    end
    stall = 1'b0;
    step();
    exp = {32'h20, 32'hFFFF_FFFF, 32'h24, 1'b1, 1'b1};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL halt_after_stall got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_halt();
    halt_addr = 32'h20;
    do_reset();
    for (int i = 0; i < 8; i++) step();
    vectors++;
    if (inst_IF !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL halt_fetch inst_IF=%h exp=ffffffff", inst_IF);
    end
    step();
    exp = {32'h20, 32'hFFFF_FFFF, 32'h24, 1'b1, 1'b1};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL halt_enter got=%h exp=%h", got, exp);
    end
    for (int i = 0; i < 11; i++) begin
      step();
      exp = {32'h20, 32'h0, 32'h0, 1'b0, 1'b1};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL halt_idle_%0d got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_reset_in_halt();
    rst = 1'b1; stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h80;
    step();
    rst = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    exp = {32'h0, 32'h0, 32'h0, 1'b0, 1'b0};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL reset_override got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_halt_with_branch();
    halt_addr = 32'h20;
    do_reset();
    for (int i = 0; i < 8; i++) step();
    branch_taken = 1'b1; branch_target = 32'h80;
    step();
    exp = {32'h80, 32'h0, 32'h0, 1'b0, 1'b0};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL halt_branch_discard got=%h exp=%h", got, exp);
    end
    branch_taken = 1'b0;
    step();
    exp = {32'h84, rom(32'h80), 32'h84, 1'b1, 1'b0};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL halt_branch_resume got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_branch_out_of_halt();
    halt_addr = 32'h20;
    do_reset();
    for (int i = 0; i < 10; i++) step();
    branch_taken = 1'b1; branch_target = 32'h100;
    step();
    branch_taken = 1'b0;
    exp = {32'h100, 32'h0, 32'h0, 1'b0, 1'b0};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL branch_from_halt got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_wrap();
    halt_addr = 32'h0000_0001;
    do_reset();
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    step();
    branch_taken = 1'b0;
    step();
    exp = {32'h0, rom(32'hFFFF_FFFC), 32'h0, 1'b1, 1'b0};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL pc_wrap got=%h exp=%h", got, exp);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_branch_over_stall();
    test_halt_stall_pending();
    test_halt();
    test_reset_in_halt();
    test_halt_with_branch();
    test_branch_out_of_halt();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
